// File: rtl/silife_sync_controller.sv
// silife_sync_controller
//
// Sequencer for one inter-tile edge-exchange boundary. Per exchange it raises
// the sync-active strobe, emits WIDTH+1 sync clock pulses (one per cell plus the
// corner), waits for the receivers to drain, then releases the bus and reports
// either done (one-cycle pulse) or a sticky timeout error.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   i_start        one-cycle exchange request (accepted only when idle)
//   i_abort        immediate return to idle, highest priority
//   i_half_period  sync clock half-period in clk cycles (floored to 4)
//   i_rx_busy      OR of all receiver busy flags on this boundary
//   o_sync_clk     registered sync clock
//   o_sync_active  registered sync-active strobe
//   o_busy         high whenever the sequencer is not idle
//   o_done         one-cycle pulse on successful completion
//   o_error        sticky drain timeout flag
//   o_bit_count    rising edges issued in the current exchange
module silife_sync_controller #(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 8,
  parameter int TIMEOUT  = 1024,
  localparam int BC_W    = $clog2(WIDTH + 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [DIV_BITS-1:0] i_half_period,
  input  logic                i_rx_busy,
  output logic                o_sync_clk,
  output logic                o_sync_active,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [BC_W-1:0]     o_bit_count
);

  // One counter serves both the half-period phases and the drain timeout, so it
  // must be wide enough for whichever limit is larger.
  localparam int CNT_MAX = (TIMEOUT > (1 << DIV_BITS)) ? TIMEOUT : (1 << DIV_BITS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    CLK_HIGH = 3'd2,
    CLK_LOW  = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIV_BITS-1:0]   h_q, h_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic                  sclk_q, sclk_d;
  logic                  act_q, act_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [DIV_BITS-1:0]   h_eff;
  logic [CNT_W-1:0]      h_m1;
  logic                  phase_end;
  logic                  drain_ok;
  logic                  drain_to;

  // Floor of 4 keeps every phase visible through the receivers' two-flop
  // synchronizer plus edge detector.
  assign h_eff = (i_half_period < DIV_BITS'(4)) ? DIV_BITS'(4) : i_half_period;

  // cnt_q is cleared on entry to a state and counts cycles spent there, so a
  // phase of H cycles ends on the edge where cnt_q reaches H-1.
  assign h_m1      = CNT_W'(h_q) - CNT_W'(1);
  assign phase_end = (cnt_q == h_m1);

  // Completion wins over timeout if both become true on the same edge.
  assign drain_ok = (cnt_q >= h_m1) && !i_rx_busy;
  assign drain_to = (cnt_q == TO_LAST);

  // State and output registers. h_q is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bc_q    <= '0;
      sclk_q  <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      sclk_q  <= sclk_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
    h_q <= h_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) state_d = SETUP;
        end
        SETUP: begin
          if (phase_end) state_d = CLK_HIGH;
        end
        CLK_HIGH: begin
          // After the corner pulse the low half-period is spent in DRAIN, so
          // the minimum drain time doubles as the final low phase.
          if (phase_end) state_d = (bc_q == LAST_BIT) ? DRAIN : CLK_LOW;
        end
        CLK_LOW: begin
          if (phase_end) state_d = (bc_q < LAST_BIT) ? CLK_HIGH : DRAIN;
        end
        DRAIN: begin
          if (drain_ok || drain_to) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    if (state_q == IDLE) cnt_d = '0;
  end

  // Registered output values.
  always_comb begin
    h_d    = h_q;
    bc_d   = bc_q;
    sclk_d = sclk_q;
    act_d  = act_q;
    done_d = 1'b0;
    err_d  = err_q;
    busy_d = (state_d != IDLE);
    if (i_abort) begin
      sclk_d = 1'b0;
      act_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            h_d    = h_eff;
            err_d  = 1'b0;
            bc_d   = '0;
            act_d  = 1'b1;
            sclk_d = 1'b0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            sclk_d = 1'b1;
            bc_d   = bc_q + BC_W'(1);
          end
        end
        CLK_HIGH: begin
          if (phase_end) sclk_d = 1'b0;
        end
        CLK_LOW: begin
          if (phase_end && (bc_q < LAST_BIT)) begin
            sclk_d = 1'b1;
            bc_d   = bc_q + BC_W'(1);
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            act_d  = 1'b0;
            done_d = 1'b1;
          end else if (drain_to) begin
            act_d  = 1'b0;
            err_d  = 1'b1;
          end
        end
        default: begin
          sclk_d = 1'b0;
          act_d  = 1'b0;
        end
      endcase
    end
  end

  assign o_sync_clk    = sclk_q;
  assign o_sync_active = act_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = err_q;
  assign o_bit_count   = bc_q;

endmodule

// File: tb/tb_silife_sync_controller.sv
// Testbench for silife_sync_controller. Two instances share all inputs: A with a
// long drain timeout, B with TIMEOUT=16. A schedule-based model predicts every
// output of both on every cycle; literal expectations pin the key timings.
module tb_silife_sync_controller;
  localparam int W    = 4;
  localparam int DB   = 8;
  localparam int TO_A = 64;
  localparam int TO_B = 16;
  localparam int BCW  = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_rx_busy = 1'b0;
  logic [DB-1:0] i_half_period = 8'd4;

  logic [1:0]     sclk, sact, sbusy, sdone, serr;
  logic [BCW-1:0] bc_a, bc_b;

  silife_sync_controller #(.WIDTH(W), .DIV_BITS(DB), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_half_period(i_half_period), .i_rx_busy(i_rx_busy),
    .o_sync_clk(sclk[0]), .o_sync_active(sact[0]), .o_busy(sbusy[0]),
    .o_done(sdone[0]), .o_error(serr[0]), .o_bit_count(bc_a));

  silife_sync_controller #(.WIDTH(W), .DIV_BITS(DB), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_half_period(i_half_period), .i_rx_busy(i_rx_busy),
    .o_sync_clk(sclk[1]), .o_sync_active(sact[1]), .o_busy(sbusy[1]),
    .o_done(sdone[1]), .o_error(serr[1]), .o_bit_count(bc_b));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int t0   = 0;
  bit chk_en = 1'b0;

  // Model state per instance.
  bit m_run[2], m_clk[2], m_act[2], m_done[2], m_err[2];
  int m_ea[2], m_h[2], m_bc[2];
  int to_lim[2] = '{TO_A, TO_B};

  // Observations relative to t0.
  int rise_q[$];
  int done_rel[2];
  int err_rel[2];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: timing derived from the exchange schedule relative to the accept edge.
  initial begin
    int t, dr, dt;
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 1'b0;
        if (reset) begin
          m_run[i] = 0; m_clk[i] = 0; m_act[i] = 0; m_err[i] = 0; m_bc[i] = 0;
        end else if (i_abort) begin
          m_run[i] = 0; m_clk[i] = 0; m_act[i] = 0;
        end else if (!m_run[i]) begin
          if (i_start) begin
            m_run[i] = 1; m_ea[i] = cyc;
            m_h[i]   = (int'(i_half_period) < 4) ? 4 : int'(i_half_period);
            m_err[i] = 0; m_bc[i] = 0; m_act[i] = 1; m_clk[i] = 0;
          end
        end else begin
          t  = cyc - m_ea[i];
          dr = 2 * m_h[i] * (W + 1);
          if (t < dr) begin
            m_clk[i] = (t >= m_h[i]) && (((t - m_h[i]) % (2 * m_h[i])) < m_h[i]);
            if (t >= m_h[i]) begin
              m_bc[i] = (t - m_h[i]) / (2 * m_h[i]) + 1;
              if (m_bc[i] > W + 1) m_bc[i] = W + 1;
            end
          end else begin
            dt = t - dr;
            m_clk[i] = 0;
            if (dt >= m_h[i] && !i_rx_busy) begin
              m_run[i] = 0; m_act[i] = 0; m_done[i] = 1;
            end else if (dt >= to_lim[i]) begin
              m_run[i] = 0; m_act[i] = 0; m_err[i] = 1;
            end
          end
        end
      end
    end
  end

  // Compare process plus event recording, away from the active edge.
  initial begin
    bit prev_clk = 1'b0;
    bit prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          string s;
          s = (i == 0) ? "A" : "B";
          chk({s, ".sync_clk"},    int'(sclk[i]),  int'(m_clk[i]));
          chk({s, ".sync_active"}, int'(sact[i]),  int'(m_act[i]));
          chk({s, ".busy"},        int'(sbusy[i]), int'(m_run[i]));
          chk({s, ".done"},        int'(sdone[i]), int'(m_done[i]));
          chk({s, ".error"},       int'(serr[i]),  int'(m_err[i]));
          chk({s, ".bit_count"},   (i == 0) ? int'(bc_a) : int'(bc_b), m_bc[i]);
          if (sdone[i]) done_rel[i] = cyc - t0;
        end
        if (sclk[0] && !prev_clk) rise_q.push_back(cyc - t0);
        if (serr[1] && !prev_err) err_rel[1] = cyc - t0;
      end
      prev_clk = sclk[0];
      prev_err = serr[1];
    end
  end

  task automatic start_x(input int hp);
    @(negedge clk);
    i_half_period = DB'(hp);
    i_start = 1'b1;
    t0 = cyc;
    rise_q.delete();
    done_rel = '{-1, -1};
    err_rel  = '{-1, -1};
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic tick_to(input int r);
    while ((cyc - t0) < r) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbusy[0] || sbusy[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_in_budget", int'(n < 300), 1);
  endtask

  task automatic check_basic(input string tag);
    int exp_r[5];
    exp_r = '{5, 13, 21, 29, 37};
    chk({tag, ".rise_count"}, rise_q.size(), 5);
    for (int k = 0; k < 5; k++)
      chk({tag, ".rise_time"}, (k < rise_q.size()) ? rise_q[k] : -1, exp_r[k]);
    chk({tag, ".A_done_time"}, done_rel[0], 45);
    chk({tag, ".B_done_time"}, done_rel[1], 45);
    chk({tag, ".bit_count"}, int'(bc_a), 5);
    chk({tag, ".error"}, int'(serr[0]), 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset.sync_clk", int'(sclk[0]), 0);
    chk("reset.sync_active", int'(sact[0]), 0);
    chk("reset.busy", int'(sbusy[0]), 0);
    chk("reset.bit_count", int'(bc_a), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal exchange, H=4
    start_x(4);
    chk("start.active_next", int'(sact[0]), 1);
    chk("start.busy_next", int'(sbusy[0]), 1);
    wait_idle();
    check_basic("h4");

    // Half-period clamps to 4
    repeat (2) @(negedge clk);
    start_x(1);
    wait_idle();
    check_basic("h1");

    // Receivers busy until T0+60: A completes late, B times out
    repeat (2) @(negedge clk);
    i_rx_busy = 1'b1;
    start_x(4);
    tick_to(60);
    i_rx_busy = 1'b0;
    wait_idle();
    chk("busy.A_done_time", done_rel[0], 61);
    chk("busy.B_no_done", done_rel[1], -1);
    chk("busy.B_error_time", err_rel[1], 57);
    chk("busy.B_error", int'(serr[1]), 1);
    chk("busy.A_error", int'(serr[0]), 0);

    // Next start clears the error; abort in CLK_HIGH after 2nd rising edge
    repeat (2) @(negedge clk);
    start_x(4);
    chk("restart.B_error_cleared", int'(serr[1]), 0);
    tick_to(14);
    chk("abort.pre_clk_high", int'(sclk[0]), 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort.sync_clk", int'(sclk[0]), 0);
    chk("abort.sync_active", int'(sact[0]), 0);
    chk("abort.busy", int'(sbusy[0]), 0);
    chk("abort.bit_count", int'(bc_a), 2);
    repeat (3) @(negedge clk);
    chk("abort.bit_count_held", int'(bc_a), 2);
    chk("abort.no_done", done_rel[0], -1);

    // Mid-exchange start ignored, then reset mid-exchange
    start_x(4);
    tick_to(10);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    tick_to(20);
    chk("midstart.bit_count", int'(bc_a), 2);
    chk("midstart.sync_clk", int'(sclk[0]), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset.sync_clk", int'(sclk[0]), 0);
    chk("midreset.sync_active", int'(sact[0]), 0);
    chk("midreset.busy", int'(sbusy[0]), 0);
    chk("midreset.done", int'(sdone[0]), 0);
    chk("midreset.error", int'(serr[0]), 0);
    chk("midreset.bit_count", int'(bc_a), 0);

    // Abort wins over a same-cycle start
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abort_start.busy", int'(sbusy[0]), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/silife_sync_controller.md
# silife_sync_controller

Sequencer for the inter-tile edge-exchange bus. On each generation it drives the shared sync clock and sync-active strobes that all edge synchronizers on one tile boundary consume. It shifts exactly WIDTH cell bits plus one corner bit, waits for every receiver to report completion, then releases the bus and reports done or timeout to the grid scheduler. It sits between the generation scheduler and the edge-sync instances, one controller per boundary.

## Interface
- WIDTH, 32: cells per edge; the controller generates WIDTH+1 sync clock pulses, one per cell plus one corner.
- DIV_BITS, 8: width of the half-period configuration input.
- TIMEOUT, 1024: maximum cycles spent in DRAIN before the controller aborts with an error.
- clk  input  1  system clock. Single clock; no other clock domain inside the block.
- reset  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request to run an exchange; ignored unless the state is IDLE.
- i_abort  input  1  forces an immediate return to IDLE from any state.
- i_half_period  input  DIV_BITS  sync clock half-period in clk cycles; sampled on an accepted start.
- i_rx_busy  input  1  OR of the o_busy outputs of all receivers on this boundary.
- o_sync_clk  output  1  registered sync clock to the edge synchronizers.
- o_sync_active  output  1  registered sync-active strobe to the edge synchronizers.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse on successful completion.
- o_error  output  1  sticky timeout flag; cleared by reset or by the next accepted start.
- o_bit_count  output  clog2(WIDTH+2)  number of rising edges issued so far in the current exchange.

## Operation
- States: IDLE, SETUP, CLK_HIGH, CLK_LOW, DRAIN.
- Effective half-period H = max(i_half_period, 4), latched when a start is accepted. The floor of 4 guarantees the receivers' two-flop synchronizer plus edge detector sees every phase.
- IDLE:
  - Outputs: o_sync_clk=0, o_sync_active=0.
  - On i_start: latch H, clear o_error and o_bit_count, set o_sync_active=1, go to SETUP.
- SETUP: clock held low for H cycles, then o_sync_clk=1, o_bit_count increments, go to CLK_HIGH.
- CLK_HIGH: hold for H cycles, then o_sync_clk=0, go to CLK_LOW.
- CLK_LOW: hold for H cycles, then:
  - if o_bit_count < WIDTH+1: raise the clock again, increment o_bit_count, go to CLK_HIGH;
  - else: go to DRAIN.
- DRAIN:
  - Clock stays low and active stays high.
  - Leave only after at least H cycles in DRAIN and once i_rx_busy==0 is sampled.
  - On leaving: o_sync_active=0, o_done=1 for one cycle, go to IDLE.
  - If TIMEOUT cycles pass in DRAIN without exit: o_sync_active=0, o_error=1, no o_done, go to IDLE.
- i_abort:
  - Has priority over every transition, including a same-cycle i_start.
  - Next cycle: o_sync_clk=0, o_sync_active=0, state IDLE, no o_done.
  - o_error and o_bit_count are left unchanged.
- Reset: equivalent to abort, and additionally clears o_error and o_bit_count. Same behaviour mid-exchange.
- A start received while busy is dropped. It is not queued.
- o_bit_count never exceeds WIDTH+1 and does not wrap.

## Timing
- All outputs are registered.
- Reset values: o_sync_clk=0, o_sync_active=0, o_busy=0, o_done=0, o_error=0, o_bit_count=0.
- Start sampled at edge T0:
  - o_sync_active=1 and o_busy=1 from T0+1.
  - Rising edge k (k=0..WIDTH) at T0+1+H+2kH.
  - Falling edge k at T0+1+2H+2kH.
  - Last falling edge at T0+1+2H(WIDTH+1).
  - Earliest o_sync_active fall and o_done pulse: T0+1+2H(WIDTH+1)+H.
- o_busy drops on the same edge that o_sync_active falls.
- A new start is accepted one cycle after o_done at the earliest.
- o_sync_clk and o_sync_active never change on the same edge, except on abort, reset or timeout.

## Test plan
- WIDTH=4, i_half_period=4, i_rx_busy=0, start at T0:
  - exactly 5 rising edges at T0+5, +13, +21, +29, +37;
  - o_sync_active falls and o_done pulses at T0+45;
  - o_bit_count=5.
- i_half_period=1: H clamps to 4; timing is identical to the previous case.
- i_rx_busy held high until T0+60:
  - DRAIN extends; o_sync_active falls and o_done pulses at T0+61.
- i_rx_busy stuck high, TIMEOUT=16:
  - o_error=1 and o_sync_active=0 at T0+41+16;
  - no o_done;
  - the next start clears o_error.
- i_abort during CLK_HIGH after the 2nd rising edge:
  - next cycle o_sync_clk=0, o_sync_active=0, o_busy=0;
  - o_bit_count stays 2; no o_done.
- i_start pulsed mid-exchange, then reset asserted mid-exchange:
  - the mid-exchange start has no effect;
  - reset returns every output to its reset value on the next edge.
